// File: rtl/sound_event_sequencer.sv
// sound_event_sequencer: converts raw collision levels into frame-timed,
// mutually exclusive sound requests for the audio processing unit.
// Sources are indexed sword=bit0, sheep=bit1, player=bit2. Event ids are
// 1=sword, 2=sheep, 3=player. A larger id means a higher priority.
module sound_event_sequencer #(
    parameter int CNT_BITS   = 5,
    parameter int DUR_SWORD  = 6,
    parameter int DUR_SHEEP  = 12,
    parameter int DUR_PLAYER = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_end,
    input  logic       sword_hit,
    input  logic       sheep_hit,
    input  logic       player_hit,
    output logic       SwordDragonCollision,
    output logic       SheepDragonCollision,
    output logic       PlayerDragonCollision,
    output logic [1:0] event_id,
    output logic       busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    // A duration of zero is treated as one frame so the counter never wraps.
    localparam logic [CNT_BITS-1:0] LEN_SWORD  = (DUR_SWORD  == 0) ? CNT_BITS'(1) : CNT_BITS'(DUR_SWORD);
    localparam logic [CNT_BITS-1:0] LEN_SHEEP  = (DUR_SHEEP  == 0) ? CNT_BITS'(1) : CNT_BITS'(DUR_SHEEP);
    localparam logic [CNT_BITS-1:0] LEN_PLAYER = (DUR_PLAYER == 0) ? CNT_BITS'(1) : CNT_BITS'(DUR_PLAYER);

    logic [1:0]          state;
    logic [2:0]          hit_q;
    logic [2:0]          pending;
    logic [CNT_BITS-1:0] remaining;

    logic [2:0]          hits;
    logic [2:0]          rise;
    logic [1:0]          rise_id;
    logic [1:0]          pend_id;
    logic [2:0]          rise_mask;
    logic [2:0]          pend_mask;

    logic [1:0]          n_state;
    logic [2:0]          n_pend;
    logic [CNT_BITS-1:0] n_rem;
    logic [1:0]          n_ev;
    logic                n_busy;

    function automatic logic [2:0] id_mask(input logic [1:0] id);
        case (id)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] top_id(input logic [2:0] v);
        if (v[2])      return 2'd3;
        else if (v[1]) return 2'd2;
        else if (v[0]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [CNT_BITS-1:0] dur_of(input logic [1:0] id);
        case (id)
            2'd1:    return LEN_SWORD;
            2'd2:    return LEN_SHEEP;
            2'd3:    return LEN_PLAYER;
            default: return '0;
        endcase
    endfunction

    assign hits      = {player_hit, sheep_hit, sword_hit};
    assign rise      = hits & ~hit_q;
    assign rise_id   = top_id(rise);
    assign pend_id   = top_id(pending);
    assign rise_mask = id_mask(rise_id);
    assign pend_mask = id_mask(pend_id);

    // Next-state logic: start, preempt, retrigger, queue and frame counting.
    always_comb begin
        n_state = state;
        n_pend  = pending;
        n_rem   = remaining;
        n_ev    = event_id;
        case (state)
            IDLE: begin
                if (rise_id != 2'd0) begin
                    n_state = PLAY;
                    n_ev    = rise_id;
                    n_rem   = dur_of(rise_id);
                    n_pend  = (pending | rise) & ~rise_mask;
                end else if (pend_id != 2'd0) begin
                    n_state = PLAY;
                    n_ev    = pend_id;
                    n_rem   = dur_of(pend_id);
                    n_pend  = pending & ~pend_mask;
                end
            end
            GAP: begin
                if (rise_id != 2'd0) begin
                    n_state = PLAY;
                    n_ev    = rise_id;
                    n_rem   = dur_of(rise_id);
                    n_pend  = (pending | rise) & ~rise_mask;
                end else if (frame_end) begin
                    if (pend_id != 2'd0) begin
                        n_state = PLAY;
                        n_ev    = pend_id;
                        n_rem   = dur_of(pend_id);
                        n_pend  = pending & ~pend_mask;
                    end else begin
                        n_state = IDLE;
                    end
                end
            end
            PLAY: begin
                if (rise_id > event_id) begin
                    // Preemption: the displaced event is dropped, not queued.
                    n_ev   = rise_id;
                    n_rem  = dur_of(rise_id);
                    n_pend = (pending | (rise & ~id_mask(event_id))) & ~rise_mask;
                end else if (rise_id == event_id) begin
                    n_rem  = dur_of(event_id);
                    n_pend = pending | (rise & ~rise_mask);
                end else begin
                    n_pend = pending | rise;
                    if (frame_end) begin
                        if (remaining <= CNT_BITS'(1)) begin
                            n_state = GAP;
                            n_ev    = 2'd0;
                            n_rem   = '0;
                        end else begin
                            n_rem = remaining - CNT_BITS'(1);
                        end
                    end
                end
            end
            default: begin
                n_state = IDLE;
                n_ev    = 2'd0;
                n_rem   = '0;
            end
        endcase
        n_busy = (n_state != IDLE) || (n_pend != 3'b000);
    end

    // State, edge-detect history and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state                 <= IDLE;
            hit_q                 <= hits;
            pending               <= 3'b000;
            remaining             <= '0;
            event_id              <= 2'd0;
            busy                  <= 1'b0;
            SwordDragonCollision  <= 1'b0;
            SheepDragonCollision  <= 1'b0;
            PlayerDragonCollision <= 1'b0;
        end else begin
            state                 <= n_state;
            hit_q                 <= hits;
            pending               <= n_pend;
            remaining             <= n_rem;
            event_id              <= n_ev;
            busy                  <= n_busy;
            SwordDragonCollision  <= (n_ev == 2'd1);
            SheepDragonCollision  <= (n_ev == 2'd2);
            PlayerDragonCollision <= (n_ev == 2'd3);
        end
    end

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Scoreboard bench for sound_event_sequencer: stimulus pushes the expected
// output change (cycle, event id, busy); a monitor pops and compares on
// every observed change of the output bundle.
module tb_sound_event_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_end = 1'b0;
    logic       sword_hit = 1'b0;
    logic       sheep_hit = 1'b0;
    logic       player_hit = 1'b0;
    logic       SwordDragonCollision;
    logic       SheepDragonCollision;
    logic       PlayerDragonCollision;
    logic [1:0] event_id;
    logic       busy;

    typedef struct {
        int         at_cycle;
        logic [1:0] ev;
        logic       busy;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       exp_item;
    int         cyc = 0;
    int         cur_edge = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [5:0] prev_obs;
    logic [5:0] obs_now;
    logic       rst_lvl = 1'b0;
    logic       sw_lvl = 1'b0;
    logic       sh_lvl = 1'b0;
    logic       pl_lvl = 1'b0;

    sound_event_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .frame_end            (frame_end),
        .sword_hit            (sword_hit),
        .sheep_hit            (sheep_hit),
        .player_hit           (player_hit),
        .SwordDragonCollision (SwordDragonCollision),
        .SheepDragonCollision (SheepDragonCollision),
        .PlayerDragonCollision(PlayerDragonCollision),
        .event_id             (event_id),
        .busy                 (busy)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Count rising edges so expectations can name the edge they belong to.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] pack_exp(input logic [1:0] ev, input logic b);
        return {ev == 2'd3, ev == 2'd2, ev == 2'd1, ev, b};
    endfunction

    function automatic logic [5:0] pack_obs();
        return {PlayerDragonCollision, SheepDragonCollision, SwordDragonCollision, event_id, busy};
    endfunction

    // One cycle of stimulus; the values are sampled by edge cur_edge.
    task automatic applyStimulus(input logic fe);
        @(negedge clk);
        reset      = rst_lvl;
        frame_end  = fe;
        sword_hit  = sw_lvl;
        sheep_hit  = sh_lvl;
        player_hit = pl_lvl;
        cur_edge   = cyc + 1;
    endtask

    task automatic quiet(input int n);
        repeat (n) applyStimulus(1'b0);
    endtask

    // n frames of 16 cycles; the frame_end pulse is on the last cycle.
    task automatic frames(input int n);
        repeat (n) begin
            quiet(15);
            applyStimulus(1'b1);
        end
    endtask

    task automatic expectChange(input int at, input logic [1:0] ev, input logic b);
        exp_t e;
        e.at_cycle = at;
        e.ev       = ev;
        e.busy     = b;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [1:0] ev, input logic b);
        logic [5:0] got;
        got = pack_obs();
        checks++;
        if (got !== pack_exp(ev, b)) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %b, required %b", name, cyc, got, pack_exp(ev, b));
        end
    endtask

    // Monitor: every change of the output bundle must match the next expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            obs_now = pack_obs();
            if (obs_now !== prev_obs) begin
                prev_obs = obs_now;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_change cycle %0d: got %b, required no change", cyc, obs_now);
                end else begin
                    exp_item = exp_q.pop_front();
                    if (cyc != exp_item.at_cycle || obs_now !== pack_exp(exp_item.ev, exp_item.busy)) begin
                        errors++;
                        $display("[TB] FAIL output_change: got %b at cycle %0d, required %b at cycle %0d",
                                 obs_now, cyc, pack_exp(exp_item.ev, exp_item.busy), exp_item.at_cycle);
                    end
                end
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        quiet(3);
        checkOutput("reset_state", 2'd0, 1'b0);
        prev_obs = pack_obs();
        mon_en   = 1'b1;
        rst_lvl  = 1'b1;
        quiet(3);

        $display("[TB] sheep event");
        sh_lvl = 1'b1; applyStimulus(1'b0); expectChange(cur_edge, 2'd2, 1'b1); sh_lvl = 1'b0;
        frames(12); expectChange(cur_edge, 2'd0, 1'b1);
        frames(1);  expectChange(cur_edge, 2'd0, 1'b0);
        quiet(5); checkOutput("idle_after_sheep", 2'd0, 1'b0);

        $display("[TB] simultaneous sword and player");
        sw_lvl = 1'b1; pl_lvl = 1'b1; applyStimulus(1'b0); expectChange(cur_edge, 2'd3, 1'b1);
        sw_lvl = 1'b0; pl_lvl = 1'b0;
        frames(20); expectChange(cur_edge, 2'd0, 1'b1);
        frames(1);  expectChange(cur_edge, 2'd1, 1'b1);
        frames(6);  expectChange(cur_edge, 2'd0, 1'b1);
        frames(1);  expectChange(cur_edge, 2'd0, 1'b0);
        quiet(5); checkOutput("idle_after_queue", 2'd0, 1'b0);

        $display("[TB] player preempts sword");
        sw_lvl = 1'b1; applyStimulus(1'b0); expectChange(cur_edge, 2'd1, 1'b1); sw_lvl = 1'b0;
        frames(3); quiet(4);
        pl_lvl = 1'b1; applyStimulus(1'b0); expectChange(cur_edge, 2'd3, 1'b1); pl_lvl = 1'b0;
        frames(20); expectChange(cur_edge, 2'd0, 1'b1);
        frames(1);  expectChange(cur_edge, 2'd0, 1'b0);
        quiet(5); checkOutput("idle_after_preempt", 2'd0, 1'b0);

        $display("[TB] sheep retrigger");
        sh_lvl = 1'b1; applyStimulus(1'b0); expectChange(cur_edge, 2'd2, 1'b1); sh_lvl = 1'b0;
        frames(5); quiet(3);
        sh_lvl = 1'b1; applyStimulus(1'b0); sh_lvl = 1'b0;
        frames(12); expectChange(cur_edge, 2'd0, 1'b1);
        frames(1);  expectChange(cur_edge, 2'd0, 1'b0);
        quiet(5); checkOutput("idle_after_retrigger", 2'd0, 1'b0);

        $display("[TB] rise coincident with frame_end");
        sw_lvl = 1'b1; applyStimulus(1'b1); expectChange(cur_edge, 2'd1, 1'b1); sw_lvl = 1'b0;
        frames(6); expectChange(cur_edge, 2'd0, 1'b1);
        frames(1); expectChange(cur_edge, 2'd0, 1'b0);
        quiet(5); checkOutput("idle_after_coincident", 2'd0, 1'b0);

        $display("[TB] player held through reset release");
        rst_lvl = 1'b0; pl_lvl = 1'b1; quiet(3);
        rst_lvl = 1'b1; quiet(5);
        checkOutput("held_through_reset", 2'd0, 1'b0);
        pl_lvl = 1'b0; quiet(2);
        pl_lvl = 1'b1; applyStimulus(1'b0); expectChange(cur_edge, 2'd3, 1'b1);
        frames(6); quiet(3);
        pl_lvl = 1'b0;
        frames(14); expectChange(cur_edge, 2'd0, 1'b1);
        frames(1);  expectChange(cur_edge, 2'd0, 1'b0);
        quiet(5); checkOutput("idle_after_long_hold", 2'd0, 1'b0);

        $display("[TB] reset mid-play with sheep pending");
        pl_lvl = 1'b1; applyStimulus(1'b0); expectChange(cur_edge, 2'd3, 1'b1); pl_lvl = 1'b0;
        frames(2);
        sh_lvl = 1'b1; applyStimulus(1'b0); sh_lvl = 1'b0;
        frames(2); quiet(3);
        rst_lvl = 1'b0; applyStimulus(1'b0); expectChange(cur_edge, 2'd0, 1'b0);
        quiet(2);
        rst_lvl = 1'b1;
        frames(15);
        checkOutput("no_pending_after_reset", 2'd0, 1'b0);

        quiet(10);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL expectations_left: got %0d unmatched, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_event_sequencer.md
# sound_event_sequencer

Converts raw collision indications from the game's collision logic into clean, frame-timed sound requests for the audio processing unit. It sits directly upstream of the audio unit and drives its three collision inputs. Each detected event is held for a fixed number of video frames. At most one request is active at a time, so the audio unit's internal priority mux never has to arbitrate. Overlapping events are resolved by fixed priority, with lower-priority events queued behind the active one.

## Interface
Parameters:
- CNT_BITS, 5: width of the frame down-counter; must hold the largest DUR_*.
- DUR_SWORD, 6: frames the sword-hit sound is held.
- DUR_SHEEP, 12: frames the sheep-hit sound is held.
- DUR_PLAYER, 20: frames the player-hit sound is held.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- frame_end  in  1  one-cycle pulse per video frame.
- sword_hit  in  1  raw sword/dragon collision level; may stay high for many cycles.
- sheep_hit  in  1  raw sheep/dragon collision level.
- player_hit  in  1  raw player/dragon collision level.
- SwordDragonCollision  out  1  registered request to the audio unit.
- SheepDragonCollision  out  1  registered request to the audio unit.
- PlayerDragonCollision  out  1  registered request to the audio unit.
- event_id  out  2  active event: 00 none, 01 sword, 10 sheep, 11 player.
- busy  out  1  1 when the state is not IDLE or any pending bit is set.

## Operation
- Edge detect: per source, hit_q holds the previous sample, and rise = hit & ~hit_q.
  - While reset=0, hit_q loads the current inputs, so a level held across reset release is not an event.
- Priority: player > sheep > sword.
- The three request outputs are one-hot or all zero, and always agree with event_id.
- State machine has three states: IDLE, PLAY, GAP.
  - IDLE: the highest-priority rise, or else the highest pending bit, loads remaining <= DUR_x and goes to PLAY. The started source's pending bit is cleared.
  - PLAY: each frame_end decrements remaining. A frame_end with remaining==1 goes to GAP and clears the outputs.
  - GAP: one silent frame. On frame_end, start the highest pending source (-> PLAY) or go to IDLE. A rise during GAP starts immediately, as in IDLE.
- Rises during PLAY, compared against the active source:
  - Higher priority: preempts. The new source loads its DUR. The preempted event is discarded, not queued.
  - Same source: retrigger. remaining reloads to DUR; the output stays high with no glitch.
  - Lower priority: sets that source's pending bit. A repeat rise while already pending has no effect, so there is at most one pending per source.
- Simultaneous rises: the highest priority acts as above. Every other rising source sets its pending bit, unless it is the active source, in which case the highest one's action dominates.
- A rise and a frame_end in the same cycle: the start or reload takes precedence, and that frame_end is not counted.
- DUR_x = 0 behaves as 1. The counter never wraps, and remaining==0 never occurs in PLAY.

## Timing
- Reset: all outputs 0, event_id=00, busy=0, state IDLE, pending=000, remaining=0. This takes effect in the cycle after reset is sampled low, including mid-PLAY.
- Latency: a rise sampled at edge t drives the request output high from t+1.
- Hold: the output is high until the clock edge that samples the DUR_x-th counted frame_end. It is low from the cycle after that edge.
- Gap: the next pending event starts one cycle after the following frame_end, so there is exactly one silent frame between queued events.
- busy falls in the same cycle the state returns to IDLE with pending=000.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Sheep event (frame_end every 16 cycles, DUR_SHEEP=12): pulse sheep_hit at cycle 10.
  - SheepDragonCollision=1 and event_id=10 from cycle 11.
  - Falls after the 12th frame_end; busy drops after the next frame_end.
- Simultaneous sword_hit and player_hit rise:
  - Player output for 20 frames, then a 1-frame gap, then sword for 6 frames.
  - The outputs are never high together.
- Sword playing, player rises at frame 3: player output from the next cycle, 20 frames.
  - Sword is not resumed; busy=0 afterwards.
- Sheep playing, sheep rises again after 5 counted frames: output continuously high for 17 frames total.
- player_hit held high through reset release: no event.
  - Then drop it and raise it for 100 cycles: exactly one 20-frame event.
- Reset driven low mid-PLAY with sheep pending: next cycle all outputs 0, busy=0.
  - The pending sheep is not played after reset releases.
